// File: rtl/async_tff_upcounter.sv
// async_tff_upcounter: 3-stage toggle flip-flop up-counter, q1 = LSB, q3 = MSB.
// Optional macro ASYNC_TFF_UPCOUNTER_RIPPLE_EN: one-edge-per-stage ripple carry emulation.
module async_tff_upcounter (
   input  logic clk,
   input  logic reset,
   output logic q1,
   output logic q2,
   output logic q3
);

   logic q1_r;
   logic q2_r;
   logic q3_r;
   logic t1_s;
   logic t2_s;
   logic t3_s;

   function automatic logic tff_next(input logic q, input logic t);
      return q ^ t;
   endfunction

`ifdef ASYNC_TFF_UPCOUNTER_RIPPLE_EN
   logic q1_prev_r;
   logic q2_prev_r;

   // Toggle enables: a stage toggles one edge after its lower neighbour fell 1->0
   always_comb begin
      t1_s = 1'b1;
      t2_s = q1_prev_r & ~q1_r;
      t3_s = q2_prev_r & ~q2_r;
   end

   // Shadow copies of the lower stages, used to detect their falling transitions
   always_ff @(posedge clk) begin
      if (reset) begin
         q1_prev_r <= 1'b0;
         q2_prev_r <= 1'b0;
      end else begin
         q1_prev_r <= q1_r;
         q2_prev_r <= q2_r;
      end
   end
`else
   // Toggle enables for a synchronous binary count
   always_comb begin
      t1_s = 1'b1;
      t2_s = q1_r;
      t3_s = q1_r & q2_r;
   end
`endif

   // The three T flip-flop stages; reset wins over toggling
   always_ff @(posedge clk) begin
      if (reset) begin
         q1_r <= 1'b0;
         q2_r <= 1'b0;
         q3_r <= 1'b0;
      end else begin
         q1_r <= tff_next(q1_r, t1_s);
         q2_r <= tff_next(q2_r, t2_s);
         q3_r <= tff_next(q3_r, t3_s);
      end
   end

   assign q1 = q1_r;
   assign q2 = q2_r;
   assign q3 = q3_r;

endmodule

// File: tb/tb_async_tff_upcounter.sv
// Self-checking bench for async_tff_upcounter (default and ripple-emulation builds).
module tb_async_tff_upcounter;

   logic clk;
   logic reset;
   logic q1;
   logic q2;
   logic q3;

   int n_cmp;
   int n_bad;

`ifdef ASYNC_TFF_UPCOUNTER_RIPPLE_EN
   // Ripple model: stage values plus toggles scheduled for the next edge.
   bit [2:0] m_bits;
   bit [2:0] m_sched;
`else
   int m_count;
`endif

   async_tff_upcounter dut (
      .clk  (clk),
      .reset(reset),
      .q1   (q1),
      .q2   (q2),
      .q3   (q3)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [2:0] model_value();
`ifdef ASYNC_TFF_UPCOUNTER_RIPPLE_EN
      return m_bits;
`else
      return 3'(m_count % 8);
`endif
   endfunction

   task automatic model_step(input logic rst);
`ifdef ASYNC_TFF_UPCOUNTER_RIPPLE_EN
      bit [2:0] old_bits;
      if (rst) begin
         m_bits  = 3'd0;
         m_sched = 3'd0;
      end else begin
         old_bits = m_bits;
         m_bits   = m_bits ^ m_sched ^ 3'b001;
         m_sched  = 3'd0;
         for (int i = 0; i < 2; i++)
            if (old_bits[i] && !m_bits[i]) m_sched[i+1] = 1'b1;
      end
`else
      if (rst) m_count = 0;
      else     m_count = m_count + 1;
`endif
   endtask

   task automatic tick();
      @(posedge clk);
      model_step(reset);
      #1;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      for (int i = 0; i < 4; i++) begin
         tick();
         n_cmp++;
         if ({q3, q2, q1} !== 3'b000) begin
            n_bad++;
            $display("FAIL reset_hold edge %0d: got %b expected 000", i, {q3, q2, q1});
         end
      end
   endtask

`ifdef ASYNC_TFF_UPCOUNTER_RIPPLE_EN
   task automatic test_ripple();
      logic [2:0] exp_seq [4];
      exp_seq[0] = 3'b001;
      exp_seq[1] = 3'b000;
      exp_seq[2] = 3'b011;
      exp_seq[3] = 3'b010;
      reset = 1'b0;
      for (int i = 0; i < 4; i++) begin
         tick();
         n_cmp++;
         if ({q3, q2, q1} !== exp_seq[i]) begin
            n_bad++;
            $display("FAIL ripple_seq step %0d: got %b expected %b", i, {q3, q2, q1}, exp_seq[i]);
         end
      end
   endtask
`else
   task automatic test_basic_count();
      reset = 1'b0;
      for (int i = 1; i <= 7; i++) begin
         tick();
         n_cmp++;
         if ({q3, q2, q1} !== 3'(i)) begin
            n_bad++;
            $display("FAIL basic_count step %0d: got %b expected %b", i, {q3, q2, q1}, 3'(i));
         end
      end
   endtask

   task automatic test_wrap();
      tick();
      n_cmp++;
      if ({q3, q2, q1} !== 3'b000) begin
         n_bad++;
         $display("FAIL wrap_to_zero: got %b expected 000", {q3, q2, q1});
      end
      tick();
      n_cmp++;
      if ({q3, q2, q1} !== 3'b001) begin
         n_bad++;
         $display("FAIL wrap_then_one: got %b expected 001", {q3, q2, q1});
      end
   endtask

   task automatic test_reset_mid();
      for (int i = 0; i < 4; i++) tick();
      n_cmp++;
      if ({q3, q2, q1} !== 3'b101) begin
         n_bad++;
         $display("FAIL mid_reach_5: got %b expected 101", {q3, q2, q1});
      end
      reset = 1'b1;
      tick();
      n_cmp++;
      if ({q3, q2, q1} !== 3'b000) begin
         n_bad++;
         $display("FAIL mid_reset: got %b expected 000", {q3, q2, q1});
      end
      reset = 1'b0;
      tick();
      n_cmp++;
      if ({q3, q2, q1} !== 3'b001) begin
         n_bad++;
         $display("FAIL mid_release: got %b expected 001", {q3, q2, q1});
      end
   endtask

   task automatic test_free_run();
      int q3_rises;
      logic q3_last;
      reset = 1'b1;
      tick();
      reset = 1'b0;
      q3_rises = 0;
      q3_last  = q3;
      for (int e = 1; e <= 16; e++) begin
         tick();
         if (q3 && !q3_last) q3_rises++;
         q3_last = q3;
         n_cmp++;
         if ({q3, q2, q1} !== 3'(e % 8)) begin
            n_bad++;
            $display("FAIL free_run edge %0d: got %b expected %b", e, {q3, q2, q1}, 3'(e % 8));
         end
      end
      n_cmp++;
      if (q3_rises != 2) begin
         n_bad++;
         $display("FAIL free_run_q3_period: got %0d q3 rises expected 2", q3_rises);
      end
   endtask
`endif

   task automatic test_random();
      logic [2:0] exp_v;
      reset = 1'b1;
      tick();
      for (int i = 0; i < 300; i++) begin
         reset = ($urandom_range(0, 9) == 0);
         tick();
         exp_v = model_value();
         n_cmp++;
         if ({q3, q2, q1} !== exp_v) begin
            n_bad++;
            $display("FAIL random cycle %0d (reset=%b): got %b expected %b", i, reset, {q3, q2, q1}, exp_v);
         end
      end
      reset = 1'b0;
   endtask

   initial begin
      n_cmp = 0;
      n_bad = 0;
      reset = 1'b1;
`ifdef ASYNC_TFF_UPCOUNTER_RIPPLE_EN
      m_bits  = 3'd0;
      m_sched = 3'd0;
`else
      m_count = 0;
`endif
      test_reset();
`ifdef ASYNC_TFF_UPCOUNTER_RIPPLE_EN
      test_ripple();
`else
      test_basic_count();
      test_wrap();
      test_reset_mid();
      test_free_run();
`endif
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
